// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master RAM arbiter: FSM states, master IDs and
// the read-return tag carried alongside each RAM read.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    localparam int LOCK_CNT_W = 8;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    function automatic arb_state_e own_state(input logic id);
        return id ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Per-master request/grant and read-return bundle. The arbiter uses the
// slave modport; the requesting engine (or the bench) uses master.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req;
    logic          lock;
    logic          we;
    logic          be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, lock, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// Shift register of {valid, id} tags that tracks reads in flight through
// the RAM and raises the issuing master's rvalid when its data emerges.
module rd_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  rd_tag_t    tag_i,
    output logic [1:0] rvalid_o
);

    rd_tag_t [DEPTH-1:0] pipe_q;
    rd_tag_t             head;

    // NOTE: the valid bits must be reset, otherwise stale tags fire rvalid
    // after reset; this is control state, not a data memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[DEPTH-2:0], tag_i};
        end
    end

    assign head            = pipe_q[DEPTH-1];
    assign rvalid_o[M_CPU] = head.valid && (head.id == M_CPU);
    assign rvalid_o[M_DMA] = head.valid && (head.id == M_DMA);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded lock sharing one synchronous RAM port
// between the CPU (m0) and the DMA/boot engine (m1).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    output logic [AW-1:0] RAMaddr,
    output logic [DW-1:0] RAMin,
    output logic          we,
    output logic          be,
    input  logic [DW-1:0] RAMout
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(MAX_LOCK - 1);

    arb_state_e            state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic gnt0, gnt1;
    logic own_dma, own_req, own_lock;

    logic          xfer;
    logic [AW-1:0] xfer_addr;
    logic [DW-1:0] xfer_wdata;
    logic          xfer_we;
    logic          xfer_be;

    rd_tag_t       tag_in;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata0_q, rdata1_q;

    assign own_dma  = (state_q == ST_OWN1);
    assign own_req  = own_dma ? m1.req  : m0.req;
    assign own_lock = own_dma ? m1.lock : m0.lock;

    // NOTE: non-blocking assignments for all state so every register
    // samples the pre-edge value regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= M_CPU;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (m0.req && (!m1.req || rr_ptr_q == M_CPU)) begin
                        gnt0 = 1'b1;
                    end else if (m1.req) begin
                        gnt1 = 1'b1;
                    end
                    if (gnt0 || gnt1) begin
                        rr_ptr_d = gnt0 ? M_DMA : M_CPU;
                        if (gnt0 ? m0.lock : m1.lock) begin
                            state_d    = own_state(gnt1);
                            lock_cnt_d = LOCK_CNT_W'(1);
                        end
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (own_req) begin
                        gnt0 = !own_dma;
                        gnt1 = own_dma;
                        if (own_lock && lock_cnt_q < LOCK_LAST) begin
                            lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                        end else begin
                            // Lock released or capped: hand priority away.
                            state_d    = ST_IDLE;
                            lock_cnt_d = '0;
                            rr_ptr_d   = !own_dma;
                        end
                    end else begin
                        state_d    = ST_IDLE;
                        lock_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign m0.gnt = gnt0;
    assign m1.gnt = gnt1;

    assign xfer       = gnt0 | gnt1;
    assign xfer_addr  = gnt1 ? m1.addr  : m0.addr;
    assign xfer_wdata = gnt1 ? m1.wdata : m0.wdata;
    assign xfer_we    = gnt1 ? m1.we    : m0.we;
    assign xfer_be    = gnt1 ? m1.be    : m0.be;

    // Address and data hold between transfers; strobes are single-cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            RAMaddr <= '0;
            RAMin   <= '0;
            we      <= 1'b0;
            be      <= 1'b0;
        end else if (xfer) begin
            RAMaddr <= xfer_addr;
            RAMin   <= xfer_wdata;
            we      <= xfer_we;
            be      <= xfer_be;
        end else begin
            we <= 1'b0;
            be <= 1'b0;
        end
    end

    assign tag_in.valid = xfer && !xfer_we;
    assign tag_in.id    = gnt1 ? M_DMA : M_CPU;

    rd_tag_pipe #(
        .DEPTH(1 + RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_i   (tag_in),
        .rvalid_o(rvalid)
    );

    // rdata shows RAMout in the rvalid cycle and holds it afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid[M_CPU]) rdata0_q <= RAMout;
            if (rvalid[M_DMA]) rdata1_q <= RAMout;
        end
    end

    assign m0.rvalid = rvalid[M_CPU];
    assign m1.rvalid = rvalid[M_DMA];
    assign m0.rdata  = rvalid[M_CPU] ? RAMout : rdata0_q;
    assign m1.rdata  = rvalid[M_DMA] ? RAMout : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: an RD_LAT=1 instance and an RD_LAT=3
// instance, each in front of a small behavioural synchronous RAM.
module tb_mem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(16), .DW(16)) a0 ();
    mem_arbiter_if #(.AW(16), .DW(16)) a1 ();
    mem_arbiter_if #(.AW(16), .DW(16)) b0 ();
    mem_arbiter_if #(.AW(16), .DW(16)) b1 ();

    logic [15:0] ram_addr1, ram_in1, ram_out1;
    logic        ram_we1, ram_be1;
    logic [15:0] ram_addr3, ram_in3, ram_out3;
    logic        ram_we3, ram_be3;

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .MAX_LOCK(8)) u_dut1 (
        .clk(clk), .reset(reset), .m0(a0), .m1(a1),
        .RAMaddr(ram_addr1), .RAMin(ram_in1), .we(ram_we1), .be(ram_be1),
        .RAMout(ram_out1)
    );

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(3), .MAX_LOCK(8)) u_dut3 (
        .clk(clk), .reset(reset), .m0(b0), .m1(b1),
        .RAMaddr(ram_addr3), .RAMin(ram_in3), .we(ram_we3), .be(ram_be3),
        .RAMout(ram_out3)
    );

    function automatic logic [15:0] ram_init(input int a);
        return (a == 16) ? 16'hBEEF : (16'h5A00 | 16'(a));
    endfunction

    // RAM contents reload whenever reset is high.
    logic [15:0] ram1 [256];
    logic [15:0] rd1_q;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram1[i] <= ram_init(i);
        end else if (ram_we1) begin
            ram1[ram_addr1[7:0]] <= ram_in1;
        end
        rd1_q <= ram1[ram_addr1[7:0]];
    end
    assign ram_out1 = rd1_q;

    logic [15:0] ram3 [256];
    logic [15:0] p3_0, p3_1, p3_2;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram3[i] <= ram_init(i);
        end else if (ram_we3) begin
            ram3[ram_addr3[7:0]] <= ram_in3;
        end
        p3_0 <= ram3[ram_addr3[7:0]];
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign ram_out3 = p3_2;

    task automatic set_m0(input logic rq, lk, w, b, input logic [15:0] ad, wd);
        a0.req = rq; a0.lock = lk; a0.we = w; a0.be = b; a0.addr = ad; a0.wdata = wd;
    endtask

    task automatic set_m1(input logic rq, lk, w, b, input logic [15:0] ad, wd);
        a1.req = rq; a1.lock = lk; a1.we = w; a1.be = b; a1.addr = ad; a1.wdata = wd;
    endtask

    task automatic set_b0(input logic rq, input logic [15:0] ad);
        b0.req = rq; b0.lock = 1'b0; b0.we = 1'b0; b0.be = 1'b0; b0.addr = ad; b0.wdata = '0;
    endtask

    task automatic idle_all();
        set_m0(0, 0, 0, 0, 16'h0, 16'h0);
        set_m1(0, 0, 0, 0, 16'h0, 16'h0);
        set_b0(0, 16'h0);
        b1.req = 0; b1.lock = 0; b1.we = 0; b1.be = 0; b1.addr = '0; b1.wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        set_m0(1, 0, 0, 0, 16'h0010, 16'h0);
        set_m1(1, 0, 0, 0, 16'h0030, 16'h0);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (a0.gnt !== 1'b0) begin n_fails++; $display("FAIL rst_gnt0: got %b want 0", a0.gnt); end
        n_checks++; if (a1.gnt !== 1'b0) begin n_fails++; $display("FAIL rst_gnt1: got %b want 0", a1.gnt); end
        n_checks++; if (ram_we1 !== 1'b0) begin n_fails++; $display("FAIL rst_we: got %b want 0", ram_we1); end
        n_checks++; if (ram_be1 !== 1'b0) begin n_fails++; $display("FAIL rst_be: got %b want 0", ram_be1); end
        n_checks++; if (ram_addr1 !== 16'h0) begin n_fails++; $display("FAIL rst_addr: got %h want 0000", ram_addr1); end
        n_checks++; if (ram_in1 !== 16'h0) begin n_fails++; $display("FAIL rst_in: got %h want 0000", ram_in1); end
        n_checks++; if (a0.rvalid !== 1'b0 || a1.rvalid !== 1'b0) begin n_fails++; $display("FAIL rst_rvalid: got %b%b want 00", a1.rvalid, a0.rvalid); end
        n_checks++; if (a0.rdata !== 16'h0 || a1.rdata !== 16'h0) begin n_fails++; $display("FAIL rst_rdata: got %h/%h want 0000/0000", a0.rdata, a1.rdata); end
        n_checks++; if (ram_addr3 !== 16'h0 || ram_we3 !== 1'b0) begin n_fails++; $display("FAIL rst_lat3: got addr %h we %b want 0000 0", ram_addr3, ram_we3); end
        idle_all();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        set_m0(1, 0, 0, 0, 16'h0010, 16'h0);
        #1;
        n_checks++; if (a0.gnt !== 1'b1 || a1.gnt !== 1'b0) begin n_fails++; $display("FAIL single_gnt: got %b%b want 01", a1.gnt, a0.gnt); end
        @(negedge clk);
        idle_all();
        n_checks++; if (ram_addr1 !== 16'h0010) begin n_fails++; $display("FAIL single_addr: got %h want 0010", ram_addr1); end
        n_checks++; if (ram_we1 !== 1'b0 || a0.rvalid !== 1'b0) begin n_fails++; $display("FAIL single_early: got we %b rvalid %b want 0 0", ram_we1, a0.rvalid); end
        @(negedge clk);
        n_checks++; if (a0.rvalid !== 1'b1) begin n_fails++; $display("FAIL single_rvalid: got %b want 1", a0.rvalid); end
        n_checks++; if (a0.rdata !== 16'hBEEF) begin n_fails++; $display("FAIL single_rdata: got %h want beef", a0.rdata); end
        n_checks++; if (a1.rvalid !== 1'b0) begin n_fails++; $display("FAIL single_m1_rvalid: got %b want 0", a1.rvalid); end
        @(negedge clk);
        n_checks++; if (a0.rvalid !== 1'b0 || a0.rdata !== 16'hBEEF) begin n_fails++; $display("FAIL single_hold: got rvalid %b rdata %h want 0 beef", a0.rvalid, a0.rdata); end
    endtask

    task automatic test_tie();
        logic e0, e1, r0, r1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_m0(k < 4, 0, 0, 0, 16'h0020, 16'h0);
            set_m1(k < 4, 0, 0, 0, 16'h0030, 16'h0);
            #1;
            e0 = (k < 4) && (k % 2 == 0);
            e1 = (k < 4) && (k % 2 == 1);
            r0 = (k == 2) || (k == 4);
            r1 = (k == 3) || (k == 5);
            n_checks++; if (a0.gnt !== e0 || a1.gnt !== e1) begin n_fails++; $display("FAIL tie_gnt[%0d]: got %b%b want %b%b", k, a1.gnt, a0.gnt, e1, e0); end
            n_checks++; if (a0.rvalid !== r0 || a1.rvalid !== r1) begin n_fails++; $display("FAIL tie_rvalid[%0d]: got %b%b want %b%b", k, a1.rvalid, a0.rvalid, r1, r0); end
            if (r0) begin
                n_checks++; if (a0.rdata !== 16'h5A20) begin n_fails++; $display("FAIL tie_rdata0[%0d]: got %h want 5a20", k, a0.rdata); end
            end
            if (r1) begin
                n_checks++; if (a1.rdata !== 16'h5A30) begin n_fails++; $display("FAIL tie_rdata1[%0d]: got %h want 5a30", k, a1.rdata); end
            end
        end
    endtask

    task automatic test_lock_cap();
        logic e0, e1, pw, pb;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            set_m1(1, 1, 1'(k % 2), 1'((k / 2) % 2), 16'(16'h0080 + k), 16'(16'h7000 + k));
            set_m0(k >= 1, 0, 0, 0, 16'h0020, 16'h0);
            #1;
            e0 = (k == 8);
            e1 = (k != 8);
            n_checks++; if (a0.gnt !== e0 || a1.gnt !== e1) begin n_fails++; $display("FAIL lock_gnt[%0d]: got %b%b want %b%b", k, a1.gnt, a0.gnt, e1, e0); end
            if (k >= 1) begin
                pw = (k - 1 == 8) ? 1'b0 : 1'((k - 1) % 2);
                pb = (k - 1 == 8) ? 1'b0 : 1'(((k - 1) / 2) % 2);
                n_checks++; if (ram_we1 !== pw || ram_be1 !== pb) begin n_fails++; $display("FAIL lock_webe[%0d]: got %b%b want %b%b", k, ram_we1, ram_be1, pw, pb); end
            end
        end
        do_reset();
    endtask

    task automatic test_write_read();
        @(negedge clk);
        set_m0(1, 0, 1, 1, 16'h0040, 16'h1234);
        #1;
        n_checks++; if (a0.gnt !== 1'b1) begin n_fails++; $display("FAIL wr_gnt: got %b want 1", a0.gnt); end
        @(negedge clk);
        set_m0(1, 0, 0, 0, 16'h0040, 16'h0);
        n_checks++; if (ram_we1 !== 1'b1 || ram_be1 !== 1'b1) begin n_fails++; $display("FAIL wr_webe: got %b%b want 11", ram_we1, ram_be1); end
        n_checks++; if (ram_addr1 !== 16'h0040 || ram_in1 !== 16'h1234) begin n_fails++; $display("FAIL wr_cmd: got %h/%h want 0040/1234", ram_addr1, ram_in1); end
        #1;
        n_checks++; if (a0.gnt !== 1'b1) begin n_fails++; $display("FAIL rd_gnt: got %b want 1", a0.gnt); end
        @(negedge clk);
        idle_all();
        n_checks++; if (ram_we1 !== 1'b0) begin n_fails++; $display("FAIL wr_we_once: got %b want 0", ram_we1); end
        n_checks++; if (a0.rvalid !== 1'b0) begin n_fails++; $display("FAIL wr_no_rvalid: got %b want 0", a0.rvalid); end
        @(negedge clk);
        n_checks++; if (a0.rvalid !== 1'b1 || a0.rdata !== 16'h1234) begin n_fails++; $display("FAIL wr_readback: got %b %h want 1 1234", a0.rvalid, a0.rdata); end
        @(negedge clk);
        n_checks++; if (a0.rvalid !== 1'b0) begin n_fails++; $display("FAIL wr_rvalid_once: got %b want 0", a0.rvalid); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        set_m1(1, 1, 0, 0, 16'h0030, 16'h0);
        #1;
        n_checks++; if (a1.gnt !== 1'b1) begin n_fails++; $display("FAIL mid_gnt1: got %b want 1", a1.gnt); end
        @(negedge clk);
        reset = 1'b1;
        set_m0(1, 0, 0, 0, 16'h0020, 16'h0);
        #1;
        n_checks++; if (a0.gnt !== 1'b0 || a1.gnt !== 1'b0) begin n_fails++; $display("FAIL mid_rst_gnt: got %b%b want 00", a1.gnt, a0.gnt); end
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (a1.rvalid !== 1'b0) begin n_fails++; $display("FAIL mid_dropped: got %b want 0", a1.rvalid); end
        n_checks++; if (ram_we1 !== 1'b0 || ram_addr1 !== 16'h0) begin n_fails++; $display("FAIL mid_ram: got we %b addr %h want 0 0000", ram_we1, ram_addr1); end
        #1;
        n_checks++; if (a0.gnt !== 1'b1 || a1.gnt !== 1'b0) begin n_fails++; $display("FAIL mid_first_tie: got %b%b want 01", a1.gnt, a0.gnt); end
        @(negedge clk);
        idle_all();
        n_checks++; if (a0.rvalid !== 1'b0 || a1.rvalid !== 1'b0) begin n_fails++; $display("FAIL mid_quiet: got %b%b want 00", a1.rvalid, a0.rvalid); end
        @(negedge clk);
        n_checks++; if (a0.rvalid !== 1'b1 || a0.rdata !== 16'h5A20) begin n_fails++; $display("FAIL mid_after: got %b %h want 1 5a20", a0.rvalid, a0.rdata); end
    endtask

    task automatic test_back_to_back();
        logic er;
        logic [15:0] ed;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            set_b0(k < 4, 16'(16'h0060 + k));
            #1;
            n_checks++; if (b0.gnt !== (k < 4)) begin n_fails++; $display("FAIL b2b_gnt[%0d]: got %b want %b", k, b0.gnt, (k < 4)); end
            er = (k >= 4) && (k <= 7);
            n_checks++; if (b0.rvalid !== er || b1.rvalid !== 1'b0) begin n_fails++; $display("FAIL b2b_rvalid[%0d]: got %b%b want 0%b", k, b1.rvalid, b0.rvalid, er); end
            if (er) begin
                ed = 16'(16'h5A60 + (k - 4));
                n_checks++; if (b0.rdata !== ed) begin n_fails++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, b0.rdata, ed); end
            end
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_lock_cap();
        test_write_read();
        test_reset_mid_read();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
